// File: rtl/lena2_a2g_caishu_rd_ctrl.sv
// ---------------------------------------------------------------------------
// lena2_a2g_caishu_rd_ctrl
// Arms the A2G ZC sample-capture block and drains the captured I/Q samples
// into a small first-word-fall-through FIFO read by the EMIF side.
//
// Ports:
//   clk_logic, rst_logic_n      logic clock, async active-low reset
//   i_arm, i_arm_ant_idx        arm pulse and antenna select (sampled on arm)
//   i_rd_start, i_abort         readout start pulse, abort pulse
//   i_ant_i_tx, i_ant_q_tx      capture-RAM I/Q read data (sample in [15:4])
//   i_rdy                       EMIF ready for o_data
//   o_emif_wr_en_tx             arm level to the capture block
//   o_emif_wr_ant_idx           antenna select to the capture block
//   o_rd_tx_ant_i/_q            per-sample read strobes (always identical)
//   o_data, o_vld               packed {4'd0,I,4'd0,Q} word and its valid
//   o_busy, o_done              not idle / readout-complete pulse
//   o_samp_cnt                  words accepted in the current readout
// ---------------------------------------------------------------------------
module lena2_a2g_caishu_rd_ctrl #(
   parameter int ADDR_W     = 15,
   parameter int NUM_SAMP   = 32768,
   parameter int ARM_CYC    = 4,
   parameter int RD_LAT     = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk_logic,
   input  logic        rst_logic_n,
   input  logic        i_arm,
   input  logic        i_arm_ant_idx,
   input  logic        i_rd_start,
   input  logic        i_abort,
   input  logic [15:0] i_ant_i_tx,
   input  logic [15:0] i_ant_q_tx,
   input  logic        i_rdy,
   output logic        o_emif_wr_en_tx,
   output logic        o_emif_wr_ant_idx,
   output logic        o_rd_tx_ant_i,
   output logic        o_rd_tx_ant_q,
   output logic [31:0] o_data,
   output logic        o_vld,
   output logic        o_busy,
   output logic        o_done,
   output logic [15:0] o_samp_cnt
);

   localparam int IW = ADDR_W + 1;           // issued counter, reaches NUM_SAMP
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;               // FIFO occupancy, reaches FIFO_DEPTH
   localparam int SW = CW + 1;               // occupancy + strobes in flight

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARM,
      S_WAIT,
      S_READ,
      S_DRAIN
   } state_t;

   state_t          state, state_d;
   logic            arm_go, rd_go;
   logic            strobe, push, pop, done_cond;
   logic [SW-1:0]   pending;
   logic [3:0]      arm_cnt;
   logic [IW-1:0]   issued;
   logic [RD_LAT:1] vld_pipe;
   logic [31:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   fifo_cnt;
   logic            wr_en_q, ant_idx_q;
   logic [15:0]     samp_cnt_q;
   logic [31:0]     word;
   logic            unused_low_bits;

   assign unused_low_bits = ^{i_ant_i_tx[3:0], i_ant_q_tx[3:0]};
   assign word = {4'd0, i_ant_i_tx[15:4], 4'd0, i_ant_q_tx[15:4]};

   // Words already in the FIFO plus strobes whose data is still on its way.
   // A strobe is only issued when that total leaves room, so every word the
   // pipe delivers has a FIFO slot reserved and the FIFO cannot overflow.
   always_comb begin
      pending = SW'(fifo_cnt);
      for (int k = 1; k <= RD_LAT; k++) pending = pending + SW'(vld_pipe[k]);
   end

   assign strobe    = (state == S_READ) && (pending < SW'(FIFO_DEPTH)) &&
                      (issued < IW'(NUM_SAMP));
   assign push      = vld_pipe[RD_LAT];
   assign pop       = (fifo_cnt != '0) && i_rdy;
   assign done_cond = (state == S_DRAIN) && (vld_pipe == '0) && (fifo_cnt == '0);

   // ---------------- FSM ----------------
   always_ff @(posedge clk_logic or negedge rst_logic_n) begin
      if (!rst_logic_n) state <= S_IDLE;
      else              state <= state_d;
   end

   always_comb begin
      state_d = state;
      arm_go  = 1'b0;
      rd_go   = 1'b0;
      if (i_abort) begin
         state_d = S_IDLE;
      end else begin
         case (state)
            // arm wins over a simultaneous start
            S_IDLE, S_WAIT: begin
               if (i_arm) begin
                  state_d = S_ARM;
                  arm_go  = 1'b1;
               end else if (i_rd_start) begin
                  state_d = S_READ;
                  rd_go   = 1'b1;
               end
            end
            S_ARM:   if (arm_cnt == 4'(ARM_CYC - 1)) state_d = S_WAIT;
            S_READ:  if (strobe && issued == IW'(NUM_SAMP - 1)) state_d = S_DRAIN;
            S_DRAIN: if (done_cond) state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   // ---------------- control / datapath ----------------
   always_ff @(posedge clk_logic or negedge rst_logic_n) begin
      if (!rst_logic_n) begin
         wr_en_q    <= 1'b0;
         ant_idx_q  <= 1'b0;
         arm_cnt    <= '0;
         issued     <= '0;
         vld_pipe   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_cnt   <= '0;
         samp_cnt_q <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) mem[k] <= '0;
      end else begin
         // level is high exactly for the cycles spent in ARM
         wr_en_q <= (state_d == S_ARM);
         if (arm_go) ant_idx_q <= i_arm_ant_idx;

         if (arm_go)              arm_cnt <= '0;
         else if (state == S_ARM) arm_cnt <= arm_cnt + 4'd1;

         if (rd_go)       issued <= '0;
         else if (strobe) issued <= issued + IW'(1);

         if (rd_go)                            samp_cnt_q <= '0;
         else if (pop && samp_cnt_q != 16'hFFFF) samp_cnt_q <= samp_cnt_q + 16'd1;

         if (i_abort) begin
            vld_pipe <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
         end else begin
            // strobe enters at stage 1; stage RD_LAT lines up with RAM data
            vld_pipe <= RD_LAT'({vld_pipe, strobe});
            if (push) begin
               mem[wr_ptr] <= word;
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
               2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
               2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
               default: fifo_cnt <= fifo_cnt;
            endcase
         end
      end
   end

   fifo_no_overflow: assert property (@(posedge clk_logic) disable iff (!rst_logic_n)
      !(push && !pop && fifo_cnt == CW'(FIFO_DEPTH)));

   assign o_emif_wr_en_tx   = wr_en_q;
   assign o_emif_wr_ant_idx = ant_idx_q;
   assign o_rd_tx_ant_i     = strobe;
   assign o_rd_tx_ant_q     = strobe;
   assign o_data            = mem[rd_ptr];
   assign o_vld             = (fifo_cnt != '0);
   assign o_busy            = (state != S_IDLE);
   assign o_done            = done_cond;
   assign o_samp_cnt        = samp_cnt_q;

endmodule

// File: tb/tb_lena2_a2g_caishu_rd_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lena2_a2g_caishu_rd_ctrl
// Two instances: dut (RD_LAT=1) and dut2 (RD_LAT=2), each with its own
// capture-RAM model returning I=addr[11:0], Q=~addr[11:0] (junk low nibble).
// Expected words are queued at readout start and popped on each accept.
// ---------------------------------------------------------------------------
module tb_lena2_a2g_caishu_rd_ctrl;
   localparam int N = 32768;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // dut (RD_LAT=1)
   logic        arm = 0, arm_ant = 0, rd_start = 0, abort = 0, rdy = 0;
   logic [15:0] ant_i = '0, ant_q = '0;
   logic        wr_en, wr_ant, rd_i, rd_q, vld, busy, done;
   logic [31:0] data;
   logic [15:0] samp_cnt;
   // dut2 (RD_LAT=2)
   logic        arm2 = 0, arm_ant2 = 0, rd_start2 = 0, abort2 = 0, rdy2 = 0;
   logic [15:0] ant_i2 = '0, ant_q2 = '0;
   logic        wr_en2, wr_ant2, rd_i2, rd_q2, vld2, busy2, done2;
   logic [31:0] data2;
   logic [15:0] samp_cnt2;

   logic [31:0] q1[$];
   logic [31:0] q2[$];

   lena2_a2g_caishu_rd_ctrl #(.RD_LAT(1)) dut (
      .clk_logic(clk), .rst_logic_n(rst_n), .i_arm(arm), .i_arm_ant_idx(arm_ant),
      .i_rd_start(rd_start), .i_abort(abort), .i_ant_i_tx(ant_i), .i_ant_q_tx(ant_q),
      .i_rdy(rdy), .o_emif_wr_en_tx(wr_en), .o_emif_wr_ant_idx(wr_ant),
      .o_rd_tx_ant_i(rd_i), .o_rd_tx_ant_q(rd_q), .o_data(data), .o_vld(vld),
      .o_busy(busy), .o_done(done), .o_samp_cnt(samp_cnt));

   lena2_a2g_caishu_rd_ctrl #(.RD_LAT(2)) dut2 (
      .clk_logic(clk), .rst_logic_n(rst_n), .i_arm(arm2), .i_arm_ant_idx(arm_ant2),
      .i_rd_start(rd_start2), .i_abort(abort2), .i_ant_i_tx(ant_i2), .i_ant_q_tx(ant_q2),
      .i_rdy(rdy2), .o_emif_wr_en_tx(wr_en2), .o_emif_wr_ant_idx(wr_ant2),
      .o_rd_tx_ant_i(rd_i2), .o_rd_tx_ant_q(rd_q2), .o_data(data2), .o_vld(vld2),
      .o_busy(busy2), .o_done(done2), .o_samp_cnt(samp_cnt2));

   // capture RAM models: address cleared by arm, advanced by each strobe
   logic [14:0] addr1 = '0, addr2 = '0;
   logic [15:0] s1i = '0, s1q = '0;
   always @(posedge clk) begin
      if (wr_en) addr1 <= '0;
      else if (rd_i) begin
         addr1 <= addr1 + 15'd1;
         ant_i <= {addr1[11:0], 4'hA};
         ant_q <= {~addr1[11:0], 4'h5};
      end
   end
   always @(posedge clk) begin
      if (wr_en2) addr2 <= '0;
      else if (rd_i2) begin
         addr2 <= addr2 + 15'd1;
         s1i   <= {addr2[11:0], 4'hA};
         s1q   <= {~addr2[11:0], 4'h5};
      end
      ant_i2 <= s1i;
      ant_q2 <= s1q;
   end

   function automatic logic [31:0] exp_word(int n);
      logic [11:0] a;
      a = n[11:0];
      return {4'd0, a, 4'd0, ~a};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++;
      if ({wr_en, wr_ant, rd_i, rd_q, vld, busy, done} !== 7'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b want=0000000", {wr_en, wr_ant, rd_i, rd_q, vld, busy, done});
      end
      checks++;
      if (data !== 32'd0 || samp_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_data got=%h/%0d want=0/0", data, samp_cnt);
      end
      checks++;
      if ({wr_en2, vld2, busy2, done2, rd_i2} !== 5'b0) begin
         errors++;
         $display("FAIL reset_dut2 got=%b want=00000", {wr_en2, vld2, busy2, done2, rd_i2});
      end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_arm();
      int en = 0, en2 = 0, stb = 0;
      arm = 1; arm_ant = 1; arm2 = 1; arm_ant2 = 0;
      tick();
      arm = 0; arm_ant = 0; arm2 = 0; arm_ant2 = 1;
      checks++;
      if ({wr_en, wr_ant, busy} !== 3'b111) begin
         errors++;
         $display("FAIL arm_first got=%b want=111", {wr_en, wr_ant, busy});
      end
      for (int c = 0; c < 10; c++) begin
         if (wr_en) en++;
         if (wr_en2) en2++;
         if (rd_i || rd_i2) stb++;
         tick();
      end
      checks++;
      if (en !== 4 || en2 !== 4) begin
         errors++;
         $display("FAIL arm_len got=%0d/%0d want=4/4", en, en2);
      end
      checks++;
      if (stb !== 0) begin
         errors++;
         $display("FAIL arm_strobe got=%0d want=0", stb);
      end
      checks++;
      if ({busy, wr_ant, wr_en, wr_ant2} !== 4'b1100) begin
         errors++;
         $display("FAIL arm_wait got=%b want=1100", {busy, wr_ant, wr_en, wr_ant2});
      end
   endtask

   // dut: full readout, i_rdy held high
   task automatic run_a();
      int bad = 0, acc = 0, stb = 0, qmis = 0;
      int first_stb = -1, first_vld = -1, done_cyc = -1, last_acc = -1;
      logic [31:0] e;
      q1.delete();
      for (int n = 0; n < N; n++) q1.push_back(exp_word(n));
      rdy = 1; rd_start = 1;
      tick();
      rd_start = 0;
      for (int c = 0; c < 40000 && done_cyc < 0; c++) begin
         if (rd_i) begin
            stb++;
            if (first_stb < 0) first_stb = c;
         end
         if (rd_i !== rd_q) qmis++;
         if (vld && first_vld < 0) first_vld = c;
         if (done === 1'b1) done_cyc = c;
         if (vld && rdy) begin
            acc++; last_acc = c;
            if (q1.size() == 0) bad++;
            else begin
               e = q1.pop_front();
               if (data !== e) bad++;
            end
         end
         tick();
      end
      checks++;
      if (done_cyc < 0) begin errors++; $display("FAIL full_timeout got=no_done want=done"); end
      checks++;
      if (bad !== 0 || q1.size() !== 0) begin
         errors++;
         $display("FAIL full_data got=bad%0d_left%0d want=0_0", bad, q1.size());
      end
      checks++;
      if (acc !== N || stb !== N) begin
         errors++;
         $display("FAIL full_count got=acc%0d_stb%0d want=%0d", acc, stb, N);
      end
      checks++;
      if (first_vld - first_stb !== 2) begin
         errors++;
         $display("FAIL full_latency got=%0d want=2", first_vld - first_stb);
      end
      checks++;
      if (done_cyc - last_acc !== 1 || done_cyc - first_stb !== N + 2) begin
         errors++;
         $display("FAIL full_done_time got=%0d/%0d want=1/%0d", done_cyc - last_acc, done_cyc - first_stb, N + 2);
      end
      checks++;
      if (samp_cnt !== 16'(N) || done !== 1'b0 || busy !== 1'b0 || qmis !== 0) begin
         errors++;
         $display("FAIL full_end got=cnt%0d_done%0b_busy%0b_qmis%0d want=cnt%0d_0_0_0", samp_cnt, done, busy, qmis, N);
      end
   endtask

   // dut2: full readout, i_rdy randomly low ~30%
   task automatic run_b();
      int bad = 0, acc = 0, stb = 0, ovf = 0, unst = 0, done_n = 0;
      logic prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      logic [31:0] e;
      q2.delete();
      for (int n = 0; n < N; n++) q2.push_back(exp_word(n));
      rd_start2 = 1;
      tick();
      rd_start2 = 0;
      for (int c = 0; c < 60000 && done_n == 0; c++) begin
         rdy2 = ($urandom_range(0, 99) >= 30);
         if (rd_i2) stb++;
         if (stb - acc > 4) ovf++;
         if (prev_stall && (!vld2 || data2 !== prev_data)) unst++;
         prev_stall = vld2 && !rdy2;
         prev_data  = data2;
         if (done2 === 1'b1) done_n++;
         if (vld2 && rdy2) begin
            acc++;
            if (q2.size() == 0) bad++;
            else begin
               e = q2.pop_front();
               if (data2 !== e) bad++;
            end
         end
         tick();
      end
      rdy2 = 0;
      checks++;
      if (done_n !== 1) begin errors++; $display("FAIL rand_done got=%0d want=1", done_n); end
      checks++;
      if (bad !== 0 || q2.size() !== 0 || acc !== N) begin
         errors++;
         $display("FAIL rand_data got=bad%0d_left%0d_acc%0d want=0_0_%0d", bad, q2.size(), acc, N);
      end
      checks++;
      if (ovf !== 0) begin errors++; $display("FAIL rand_outstanding got=%0d want=0", ovf); end
      checks++;
      if (unst !== 0) begin errors++; $display("FAIL rand_stable got=%0d want=0", unst); end
      checks++;
      if (samp_cnt2 !== 16'(N)) begin errors++; $display("FAIL rand_cnt got=%0d want=%0d", samp_cnt2, N); end
   endtask

   task automatic test_full_readout();
      fork
         run_a();
         run_b();
      join
   endtask

   // readout right after a full one: addresses must have wrapped to 0
   task automatic test_hold_stall();
      int stb = 0, bad = 0, acc = 0;
      logic [31:0] e;
      q1.delete();
      for (int n = 0; n < 40; n++) q1.push_back(exp_word(n));
      rdy = 0; rd_start = 1;
      tick();
      rd_start = 0;
      for (int c = 0; c < 12; c++) begin
         if (rd_i) stb++;
         tick();
      end
      checks++;
      if (stb !== 4) begin errors++; $display("FAIL hold_strobes got=%0d want=4", stb); end
      checks++;
      if (vld !== 1'b1 || data !== exp_word(0)) begin
         errors++;
         $display("FAIL hold_head got=%0b/%h want=1/%h", vld, data, exp_word(0));
      end
      rdy = 1;
      for (int c = 0; c < 200 && acc < 20; c++) begin
         if (vld && rdy) begin
            acc++;
            e = q1.pop_front();
            if (data !== e) bad++;
         end
         if (acc < 20) tick();
      end
      abort = 1;
      tick();
      abort = 0; rdy = 0;
      checks++;
      if (bad !== 0 || acc !== 20) begin
         errors++;
         $display("FAIL hold_resume got=bad%0d_acc%0d want=0_20", bad, acc);
      end
   endtask

   task automatic read_words(input int want, output int bad, output int acc);
      logic [31:0] e;
      bad = 0; acc = 0;
      q1.delete();
      for (int n = 0; n < want; n++) q1.push_back(exp_word(n));
      rdy = 1; rd_start = 1;
      tick();
      rd_start = 0;
      for (int c = 0; c < 400 && acc < want; c++) begin
         if (vld && rdy) begin
            acc++;
            e = q1.pop_front();
            if (data !== e) bad++;
         end
         if (acc < want) tick();
      end
      abort = 1;
      tick();
      abort = 0;
   endtask

   task automatic test_abort();
      int bad, acc, dn = 0, vl = 0;
      arm = 1;
      tick();
      arm = 0;
      repeat (6) tick();
      read_words(100, bad, acc);
      checks++;
      if (bad !== 0 || acc !== 100) begin
         errors++;
         $display("FAIL abort_pre_data got=bad%0d_acc%0d want=0_100", bad, acc);
      end
      checks++;
      if ({vld, rd_i, busy, done} !== 4'b0 || samp_cnt !== 16'd100) begin
         errors++;
         $display("FAIL abort_next got=%b_cnt%0d want=0000_cnt100", {vld, rd_i, busy, done}, samp_cnt);
      end
      for (int c = 0; c < 6; c++) begin
         if (done) dn++;
         if (vld || rd_i) vl++;
         tick();
      end
      checks++;
      if (dn !== 0 || vl !== 0) begin errors++; $display("FAIL abort_quiet got=%0d/%0d want=0/0", dn, vl); end
      arm = 1;
      tick();
      arm = 0;
      repeat (6) tick();
      read_words(8, bad, acc);
      checks++;
      if (bad !== 0 || acc !== 8 || samp_cnt !== 16'd8) begin
         errors++;
         $display("FAIL abort_rearm got=bad%0d_acc%0d_cnt%0d want=0_8_8", bad, acc, samp_cnt);
      end
      rdy = 0;
   endtask

   task automatic test_arm_and_start();
      int stb = 0;
      arm = 1; rd_start = 1;
      tick();
      arm = 0; rd_start = 0;
      checks++;
      if ({wr_en, busy} !== 2'b11) begin errors++; $display("FAIL both_arm got=%b want=11", {wr_en, busy}); end
      for (int c = 0; c < 3; c++) begin
         if (rd_i) stb++;
         tick();
      end
      abort = 1;
      if (rd_i) stb++;
      tick();
      abort = 0;
      checks++;
      if (stb !== 0) begin errors++; $display("FAIL both_strobe got=%0d want=0", stb); end
      checks++;
      if ({wr_en, busy, vld} !== 3'b0) begin
         errors++;
         $display("FAIL arm_abort got=%b want=000", {wr_en, busy, vld});
      end
   endtask

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_arm();
      test_full_readout();
      test_hold_stall();
      test_abort();
      test_arm_and_start();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
